// File: rtl/dbus_responder_if.sv
// Data-bus request/response bundle for dbus_responder.
// master = requester side, slave = responder side.
interface dbus_responder_if;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        dresp_err;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err
  );
endinterface

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus responder backed by a DEPTH x 64-bit memory.
// Optional DBUS_ALIGN_CHECK_EN rejects misaligned requests with dresp_err.
module dbus_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dbus_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       strobe_q, strobe_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             accept;
  logic             misalign;

  logic [63:0] mem_q [DEPTH] = '{default: '0};

`ifdef DBUS_ALIGN_CHECK_EN
  logic [2:0] size_mask;
  logic       unused_addr_bits;

  always_comb begin
    size_mask = 3'b111;
    case (bus.dreq_size)
      3'd0:    size_mask = 3'b000;
      3'd1:    size_mask = 3'b001;
      3'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  end

  assign misalign         = |(bus.dreq_addr[2:0] & size_mask);
  assign unused_addr_bits = ^bus.dreq_addr[63:3+IDX_W];
  assign bus.dresp_err    = (state_q == S_RESP) & err_q;
`else
  logic unused_addr_bits;

  assign misalign         = 1'b0;
  assign unused_addr_bits = ^{bus.dreq_addr[63:3+IDX_W], bus.dreq_addr[2:0], bus.dreq_size};
  assign bus.dresp_err    = 1'b0;
`endif

  // Only the word index and the alignment verdict are kept from addr/size,
  // which is all the later states ever look at.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.dreq_valid) begin
          accept   = 1'b1;
          idx_d    = bus.dreq_addr[3 +: IDX_W];
          strobe_d = bus.dreq_strobe;
          wdata_d  = bus.dreq_data;
          err_d    = misalign;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // Read is combinational in RESP, so the write at the RESP edge returns old data.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_RESP) && !err_q) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (strobe_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.dresp_addr_ok = reset & accept;
  assign bus.dresp_data_ok = (state_q == S_RESP);
  assign bus.dresp_data    = ((state_q == S_RESP) && !err_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed, table-driven bench for dbus_responder (DEPTH=256, LATENCY=2),
// plus hand sequences for reset abort and back-to-back held requests.
module tb_dbus_responder;

  localparam int LAT = 2;
`ifdef DBUS_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dbus_responder_if bus();

  dbus_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int id, input logic [63:0] addr, input logic [2:0] size,
                         input logic [7:0] strobe, input logic [63:0] wdata,
                         input logic [63:0] exp_data, input logic exp_err);
    int n;
    bit got;
    @(negedge clk);
    bus.dreq_addr   = addr;
    bus.dreq_size   = size;
    bus.dreq_strobe = strobe;
    bus.dreq_data   = wdata;
    bus.dreq_valid  = 1'b1;
    #1;
    n = 0;
    while (!bus.dresp_addr_ok && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check($sformatf("txn%0d accept", id), 64'(bus.dresp_addr_ok), 64'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); #1; n++;
      if (bus.dresp_data_ok) got = 1'b1;
    end
    check($sformatf("txn%0d latency", id), 64'(n), 64'(LAT));
    check($sformatf("txn%0d data", id), bus.dresp_data, exp_data);
    check($sformatf("txn%0d err", id), 64'(bus.dresp_err), 64'(exp_err));
    bus.dreq_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int acc_t[$];
    int dok;
    int extra_dok;

    vecs[0]  = '{64'h10,  3'd3, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0};
    vecs[1]  = '{64'h10,  3'd3, 8'h00, 64'h0, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{64'h18,  3'd3, 8'h0F, 64'hAAAAAAAABBBBBBBB, 64'h0, 1'b0};
    vecs[3]  = '{64'h18,  3'd3, 8'h00, 64'h0, 64'h00000000BBBBBBBB, 1'b0};
    vecs[4]  = '{64'h800, 3'd3, 8'hFF, 64'h5, 64'h0, 1'b0};
    vecs[5]  = '{64'h0,   3'd3, 8'h00, 64'h0, 64'h5, 1'b0};
    vecs[6]  = '{64'h11,  3'd0, 8'h02, 64'h000000000000CC00, 64'h1122334455667788, 1'b0};
    vecs[7]  = '{64'h13,  3'd0, 8'h00, 64'h0, 64'h112233445566CC88, 1'b0};
    vecs[8]  = '{64'h22,  3'd2, 8'hF0, 64'hDEADBEEF00000000, 64'h0, ALIGN};
    vecs[9]  = '{64'h20,  3'd3, 8'h00, 64'h0, (ALIGN ? 64'h0 : 64'hDEADBEEF00000000), 1'b0};
    vecs[10] = '{64'h0C,  3'd3, 8'h00, 64'h0, 64'h0, ALIGN};

    // Reset: valid held high must not produce addr_ok while reset is low.
    reset           = 1'b0;
    bus.dreq_valid  = 1'b1;
    bus.dreq_addr   = '0;
    bus.dreq_size   = 3'd3;
    bus.dreq_strobe = '0;
    bus.dreq_data   = '0;
    @(negedge clk); @(negedge clk); #1;
    check("reset addr_ok", 64'(bus.dresp_addr_ok), 64'd0);
    check("reset data_ok", 64'(bus.dresp_data_ok), 64'd0);
    check("reset err",     64'(bus.dresp_err),     64'd0);
    check("reset data",    bus.dresp_data,         64'd0);
    bus.dreq_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Reset in WAIT aborts a write to 0x20.
    @(negedge clk);
    bus.dreq_addr   = 64'h20;
    bus.dreq_size   = 3'd3;
    bus.dreq_strobe = 8'hFF;
    bus.dreq_data   = 64'hFFFFFFFFFFFFFFFF;
    bus.dreq_valid  = 1'b1;
    #1;
    check("abort accept", 64'(bus.dresp_addr_ok), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("abort addr_ok in reset", 64'(bus.dresp_addr_ok), 64'd0);
    bus.dreq_valid = 1'b0;
    reset          = 1'b1;
    extra_dok      = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.dresp_data_ok) extra_dok++;
      @(negedge clk); #1;
    end
    check("abort no data_ok", 64'(extra_dok), 64'd0);
    run_txn(100, 64'h20, 3'd3, 8'h00, 64'h0, 64'h0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      run_txn(i, vecs[i].addr, vecs[i].size, vecs[i].strobe, vecs[i].data,
              vecs[i].exp_data, vecs[i].exp_err);
    end

    // Held-valid back-to-back reads: one accept per transaction, LAT+1 apart.
    @(negedge clk);
    bus.dreq_addr   = 64'h10;
    bus.dreq_size   = 3'd3;
    bus.dreq_strobe = 8'h00;
    bus.dreq_valid  = 1'b1;
    dok = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (bus.dresp_addr_ok) acc_t.push_back(c);
      if (bus.dresp_data_ok) begin
        dok++;
        check($sformatf("b2b data %0d", dok), bus.dresp_data, 64'h112233445566CC88);
        if (dok == 3) bus.dreq_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b accept count", 64'(acc_t.size()), 64'd3);
    check("b2b data_ok count", 64'(dok), 64'd3);
    if (acc_t.size() >= 3) begin
      check("b2b gap 1", 64'(acc_t[1] - acc_t[0]), 64'(LAT + 1));
      check("b2b gap 2", 64'(acc_t[2] - acc_t[1]), 64'(LAT + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
